ara_fpga_rst_seq: RTL and testbench

//  Reset sequencer directly upstream of the FPGA top-level SoC/debug-module reset fan-out.

---
 rtl/ara_fpga_rst_pkg.sv | 26 ++
 rtl/ara_fpga_rst_sync.sv | 23 ++
 rtl/ara_fpga_rst_seq.sv | 135 +++++++++++++
 tb/tb_ara_fpga_rst_seq.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ara_fpga_rst_pkg.sv
// Shared types, default parameters and counter sizing for the FPGA reset sequencer.
package ara_fpga_rst_pkg;

  typedef enum logic [2:0] {
    RST_WAIT_LOCK = 3'd0,
    RST_LOCK_FILT = 3'd1,
    RST_DM_REL    = 3'd2,
    RST_RUN       = 3'd3,
    RST_NDM_RST   = 3'd4
  } rst_seq_state_e;

  localparam int DefSyncStages       = 2;
  localparam int DefLockFilterCycles = 256;
  localparam int DefSocDelayCycles   = 16;
  localparam int DefNdmMinCycles     = 4;

  // One extra bit over the largest count keeps the terminal compares free of wrap concerns.
  function automatic int rst_cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/ara_fpga_rst_sync.sv
// N-stage synchroniser for a single asynchronous level into core_clk, cleared by sys_rst_n.
module ara_fpga_rst_sync #(
  parameter int Stages = 2
) (
  input  logic core_clk,
  input  logic sys_rst_n,
  input  logic d_i,
  output logic q_o
);

  (* ASYNC_REG = "TRUE" *) logic [Stages-1:0] sync_q;

  always_ff @(posedge core_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/ara_fpga_rst_seq.sv
// Reset sequencer: qualifies PLL lock, releases debug-module then SoC reset, handles ndmreset.
// Optional lock monitoring after release is enabled by defining ARA_RST_SEQ_LOCK_MONITOR_EN.
module ara_fpga_rst_seq
  import ara_fpga_rst_pkg::*;
#(
  parameter int SyncStages       = DefSyncStages,
  parameter int LockFilterCycles = DefLockFilterCycles,
  parameter int SocDelayCycles   = DefSocDelayCycles,
  parameter int NdmMinCycles     = DefNdmMinCycles
) (
  input  logic       core_clk,
  input  logic       sys_rst_n,
  input  logic       pll_locked_i,
  input  logic       ndmreset_i,
  output logic       rst_dm_no,
  output logic       rst_soc_no,
  output logic       rst_done_o,
  output logic [2:0] state_o,
  output logic       lock_lost_o
);

  // state     | meaning
  // WAIT_LOCK | both resets held, waiting for synchronised lock
  // LOCK_FILT | lock must stay high LockFilterCycles cycles
  // DM_REL    | debug module released, SoC release delay running
  // RUN       | everything released
  // NDM_RST   | SoC reset re-asserted by debug ndmreset
  localparam logic [2:0] StWaitLock = RST_WAIT_LOCK;
  localparam logic [2:0] StLockFilt = RST_LOCK_FILT;
  localparam logic [2:0] StDmRel    = RST_DM_REL;
  localparam logic [2:0] StRun      = RST_RUN;
  localparam logic [2:0] StNdmRst   = RST_NDM_RST;

  localparam int CntW = rst_cnt_width(LockFilterCycles, SocDelayCycles, NdmMinCycles);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] LfLast  = CntW'(LockFilterCycles - 1);
  localparam logic [CntW-1:0] SdLast  = CntW'(SocDelayCycles - 1);
  localparam logic [CntW-1:0] NdmLast = CntW'(NdmMinCycles - 1);

`ifdef ARA_RST_SEQ_LOCK_MONITOR_EN
  localparam bit LockMonEn = 1'b1;
`else
  localparam bit LockMonEn = 1'b0;
`endif

  logic            lock_s;
  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            lock_lost_q, lock_lost_d;
  logic            rst_dm_q, rst_soc_q, done_q;

  ara_fpga_rst_sync #(
    .Stages (SyncStages)
  ) u_lock_sync (
    .core_clk  (core_clk),
    .sys_rst_n (sys_rst_n),
    .d_i       (pll_locked_i),
    .q_o       (lock_s)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lock_lost_d = lock_lost_q;
    case (state_q)
      StWaitLock: begin
        if (lock_s) state_d = StLockFilt;
      end
      StLockFilt: begin
        if (!lock_s)               state_d = StWaitLock;
        else if (cnt_q == LfLast)  state_d = StDmRel;
        else                       cnt_d   = cnt_q + CntOne;
      end
      StDmRel: begin
        if (!lock_s) begin
          state_d     = StWaitLock;
          lock_lost_d = 1'b1;
        end else if (ndmreset_i) begin
          cnt_d = '0;
        end else if (cnt_q == SdLast) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StRun: begin
        if (LockMonEn && !lock_s) begin
          state_d     = StWaitLock;
          lock_lost_d = 1'b1;
        end else if (ndmreset_i) begin
          state_d = StNdmRst;
        end
      end
      StNdmRst: begin
        // Counter parks at its terminal value so a long request just holds the pulse.
        if (LockMonEn && !lock_s) begin
          state_d     = StWaitLock;
          lock_lost_d = 1'b1;
        end else if (!ndmreset_i && cnt_q == NdmLast) begin
          state_d = StRun;
        end else if (cnt_q != NdmLast) begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: state_d = StWaitLock;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Outputs decode state_d so each reset changes on the same edge as the state.
  always_ff @(posedge core_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= StWaitLock;
      cnt_q       <= '0;
      lock_lost_q <= 1'b0;
      rst_dm_q    <= 1'b0;
      rst_soc_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lock_lost_q <= lock_lost_d;
      rst_dm_q    <= (state_d == StDmRel) || (state_d == StRun) || (state_d == StNdmRst);
      rst_soc_q   <= (state_d == StRun);
      done_q      <= (state_d == StRun);
    end
  end

  assign rst_dm_no   = rst_dm_q;
  assign rst_soc_no  = rst_soc_q;
  assign rst_done_o  = done_q;
  assign state_o     = state_q;
  assign lock_lost_o = lock_lost_q;

endmodule

// File: tb/tb_ara_fpga_rst_seq.sv
// Bench for ara_fpga_rst_seq: per-edge expectations from a window/run-length model of the sequence rules.
module tb_ara_fpga_rst_seq;

  localparam int SYNC = 2;
  localparam int LF   = 8;
  localparam int SD   = 4;
  localparam int NDM  = 4;
  localparam int NMAX = 200;

  localparam logic [2:0] ST_WAIT = 3'd0;
  localparam logic [2:0] ST_LF   = 3'd1;
  localparam logic [2:0] ST_DM   = 3'd2;
  localparam logic [2:0] ST_RUN  = 3'd3;
  localparam logic [2:0] ST_NDM  = 3'd4;

`ifdef ARA_RST_SEQ_LOCK_MONITOR_EN
  localparam bit MON = 1'b1;
`else
  localparam bit MON = 1'b0;
`endif

  logic       core_clk;
  logic       sys_rst_n;
  logic       pll_locked_i;
  logic       ndmreset_i;
  logic       rst_dm_no;
  logic       rst_soc_no;
  logic       rst_done_o;
  logic [2:0] state_o;
  logic       lock_lost_o;

  int errors = 0;
  int checks = 0;

  bit         pll_a   [NMAX];
  bit         ndm_a   [NMAX];
  bit         seen    [NMAX];
  bit         exp_dm  [NMAX];
  bit         exp_soc [NMAX];
  bit         exp_lost[NMAX];
  logic [2:0] exp_st  [NMAX];

  int dm_rise, soc_rise, soc_low;

  ara_fpga_rst_seq #(
    .SyncStages       (SYNC),
    .LockFilterCycles (LF),
    .SocDelayCycles   (SD),
    .NdmMinCycles     (NDM)
  ) dut (
    .core_clk     (core_clk),
    .sys_rst_n    (sys_rst_n),
    .pll_locked_i (pll_locked_i),
    .ndmreset_i   (ndmreset_i),
    .rst_dm_no    (rst_dm_no),
    .rst_soc_no   (rst_soc_no),
    .rst_done_o   (rst_done_o),
    .state_o      (state_o),
    .lock_lost_o  (lock_lost_o)
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic put(input int k, input bit dm, input bit soc, input logic [2:0] st, input bit lost);
    exp_dm[k]   = dm;
    exp_soc[k]  = soc;
    exp_st[k]   = st;
    exp_lost[k] = lost;
  endtask

  task automatic clear_stim();
    for (int i = 0; i < NMAX; i++) begin
      pll_a[i] = 1'b1;
      ndm_a[i] = 1'b0;
    end
  endtask

  // Edge k sees the lock value sampled SYNC edges earlier. Release of rst_dm needs LF+1
  // consecutive high observations after the last restart; SoC release needs SD edges of
  // ndmreset low after entering DM_REL; an ndm pulse holds SoC reset until ndm is low and
  // at least NDM edges have passed.
  task automatic build_model(input int n);
    int  x, k, d, r, drop, s;
    bit  ok, lost, in_ndm;
    for (int i = 0; i < n; i++) seen[i] = (i >= SYNC) ? pll_a[i-SYNC] : 1'b0;
    x = -1; k = 0; lost = 1'b0;
    while (k < n) begin
      d = n;
      for (int j = x + 1 + LF; j < n && d == n; j++) begin
        ok = 1'b1;
        for (int t = j - LF; t <= j; t++) if (!seen[t]) ok = 1'b0;
        if (ok) d = j;
      end
      while (k < d && k < n) begin
        put(k, 1'b0, 1'b0, seen[k] ? ST_LF : ST_WAIT, lost);
        k++;
      end
      if (d >= n) break;
      r = n; drop = n;
      for (int j = d + 1; j < n && r == n && drop == n; j++) begin
        if (!seen[j]) drop = j;
        else if (j >= d + SD) begin
          ok = 1'b1;
          for (int t = j - SD + 1; t <= j; t++) if (ndm_a[t]) ok = 1'b0;
          if (ok) r = j;
        end
      end
      while (k < r && k < drop && k < n) begin
        put(k, 1'b1, 1'b0, ST_DM, lost);
        k++;
      end
      if (drop < n) begin
        lost = 1'b1;
        x = drop;
        continue;
      end
      if (r >= n) break;
      in_ndm = 1'b0; s = 0;
      while (k < n) begin
        if (MON && k > r && !seen[k]) break;
        if (k > r) begin
          if (!in_ndm && ndm_a[k]) begin
            in_ndm = 1'b1;
            s = k;
          end else if (in_ndm && !ndm_a[k] && k >= s + NDM) begin
            in_ndm = 1'b0;
          end
        end
        put(k, 1'b1, !in_ndm, in_ndm ? ST_NDM : ST_RUN, lost);
        k++;
      end
      if (k < n) begin
        lost = 1'b1;
        x = k;
      end
    end
  endtask

  // Asserts reset mid-cycle (checks the asynchronous clear), holds it, releases on a falling edge.
  task automatic do_reset(input string name);
    @(negedge core_clk);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk({name, ".async_dm"},   rst_dm_no,   0);
    chk({name, ".async_soc"},  rst_soc_no,  0);
    chk({name, ".async_done"}, rst_done_o,  0);
    chk({name, ".async_st"},   state_o,     ST_WAIT);
    chk({name, ".async_lost"}, lock_lost_o, 0);
    pll_locked_i = 1'b1;
    ndmreset_i   = 1'b1;
    repeat (3) @(negedge core_clk);
    chk({name, ".hold_dm"}, rst_dm_no, 0);
    chk({name, ".hold_st"}, state_o,   ST_WAIT);
    ndmreset_i = 1'b0;
    sys_rst_n  = 1'b1;
  endtask

  task automatic run_scn(input string name, input int n);
    build_model(n);
    dm_rise = -1; soc_rise = -1; soc_low = 0;
    for (int e = 0; e < n; e++) begin
      pll_locked_i = pll_a[e];
      ndmreset_i   = ndm_a[e];
      @(negedge core_clk);
      chk($sformatf("%s.dm@%0d", name, e),   rst_dm_no,   exp_dm[e]);
      chk($sformatf("%s.soc@%0d", name, e),  rst_soc_no,  exp_soc[e]);
      chk($sformatf("%s.done@%0d", name, e), rst_done_o,  exp_soc[e]);
      chk($sformatf("%s.st@%0d", name, e),   state_o,     exp_st[e]);
      chk($sformatf("%s.lost@%0d", name, e), lock_lost_o, exp_lost[e]);
      if (rst_dm_no && dm_rise < 0) dm_rise = e;
      if (soc_rise >= 0 && !rst_soc_no) soc_low++;
      if (rst_soc_no && soc_rise < 0) soc_rise = e;
    end
  endtask

  initial begin
    int p, w, i, len;
    sys_rst_n    = 1'b0;
    pll_locked_i = 1'b0;
    ndmreset_i   = 1'b0;
    repeat (2) @(negedge core_clk);

    // Clean power-up with lock already present.
    do_reset("pwrup");
    clear_stim();
    run_scn("pwrup", 24);
    chk("pwrup.dm_rise_edge",  dm_rise,  10);
    chk("pwrup.soc_rise_edge", soc_rise, 14);

    // One-cycle lock glitch during filtering restarts qualification.
    do_reset("glitch");
    clear_stim();
    pll_a[5] = 1'b0;
    run_scn("glitch", 40);
    chk("glitch.dm_rise_edge",  dm_rise,  16);
    chk("glitch.soc_rise_edge", soc_rise, 20);

    // Random lock glitches, some landing in DM_REL.
    for (int rep = 0; rep < 4; rep++) begin
      do_reset("rglitch");
      clear_stim();
      for (int g = 0; g < $urandom_range(3, 1); g++) begin
        p = $urandom_range(30, 0);
        w = $urandom_range(3, 1);
        for (int q = p; q < p + w; q++) pll_a[q] = 1'b0;
      end
      run_scn($sformatf("rglitch%0d", rep), 70);
    end

    // ndmreset during DM_REL, a short pulse and a long pulse in RUN.
    do_reset("ndm");
    clear_stim();
    for (int q = 12; q <= 17; q++) ndm_a[q] = 1'b1;
    ndm_a[30] = 1'b1;
    for (int q = 45; q <= 64; q++) ndm_a[q] = 1'b1;
    run_scn("ndm", 80);
    chk("ndm.soc_rise_edge", soc_rise, 21);
    chk("ndm.soc_low_total", soc_low,  NDM + 20);

    // Random ndmreset traffic from power-up onward.
    for (int rep = 0; rep < 2; rep++) begin
      do_reset("rndm");
      clear_stim();
      i = 0;
      while (i < 160) begin
        i += $urandom_range(8, 1);
        len = $urandom_range(10, 1);
        for (int q = 0; q < len; q++) begin
          if (i < 160) ndm_a[i] = 1'b1;
          i++;
        end
      end
      run_scn($sformatf("rndm%0d", rep), 160);
    end

    // Lock drop while in DM_REL: sticky flag, then requalification.
    do_reset("dmdrop");
    clear_stim();
    for (int q = 9; q <= 11; q++) pll_a[q] = 1'b0;
    run_scn("dmdrop", 50);
    chk("dmdrop.lost_final", lock_lost_o, 1);
    chk("dmdrop.soc_final",  rst_soc_no,  1);

    // Lock drop in RUN: only acted on with the lock monitor built in.
    do_reset("rundrop");
    clear_stim();
    for (int q = 20; q <= 22; q++) pll_a[q] = 1'b0;
    run_scn("rundrop", 50);
    chk("rundrop.lost_final", lock_lost_o, MON);

    // Board reset clears the sticky flag.
    do_reset("final");
    #1;
    chk("final.lost_cleared", lock_lost_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
